// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI slave command receiver.
package spi_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 14;

    localparam int RW_BIT  = 7;
    localparam int RSV_BIT = 6;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RD_FETCH,
        RD_ARM,
        RD_SHIFT,
        WR_DATA,
        WR_COMMIT,
        WAIT_CS
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with rise/fall detection on the synced level.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            prev <= sync[STAGES-1];
        end
    end

    assign rise = sync[STAGES-1] & ~prev;
    assign fall = ~sync[STAGES-1] & prev;

endmodule

// File: rtl/spi_slave_cmd_rx.sv
// SPI slave command front end: header decode, register read fetch for the
// MISO shifter, and write-word collection with a single commit strobe.
module spi_slave_cmd_rx
    import spi_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              sck,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] in_p2s,
    output logic              head_flag,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_rd_en,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              reg_wr_en,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic              frame_err
);

    localparam int HDR_W = ADDR_W + 2;
    localparam int CNT_W = $clog2(DATA_W);

    spi_state_e state, state_nxt;

    logic sck_rise, sck_fall;
    logic cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic mosi_s;

    logic [DATA_W-2:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic [HDR_W-1:0]  hdr_word;
    logic [DATA_W-1:0] wr_word;
    logic hdr_last, wr_last;
    logic abort, rsv_hit;
    logic cs_early;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk  (clk),
        .rstn (rstn),
        .din  (sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    // cs idles high, so its chain resets high to avoid a false edge
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk  (clk),
        .rstn (rstn),
        .din  (cs),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s   = mosi_q[SYNC_STAGES-1];
    assign hdr_word = {shreg[HDR_W-2:0], mosi_s};
    assign wr_word  = {shreg, mosi_s};
    assign hdr_last = (state == HDR) && sck_rise
                   && (cnt == CNT_W'(HDR_W - 1));
    assign wr_last  = (state == WR_DATA) && sck_rise
                   && (cnt == CNT_W'(DATA_W - 1));
    assign rsv_hit  = hdr_last && !cs_rise && hdr_word[RSV_BIT];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall) state_nxt = HDR;
            end
            HDR: begin
                if (cs_rise) begin
                    abort = 1'b1;
                end else if (hdr_last) begin
                    if (hdr_word[RSV_BIT])     state_nxt = WAIT_CS;
                    else if (hdr_word[RW_BIT]) state_nxt = RD_FETCH;
                    else                       state_nxt = WR_DATA;
                end
            end
            // first cycle issues the strobe, second captures the data
            RD_FETCH: begin
                if (cs_rise)         abort     = 1'b1;
                else if (!reg_rd_en) state_nxt = RD_ARM;
            end
            RD_ARM: begin
                if (cs_rise)       abort     = 1'b1;
                else if (sck_fall) state_nxt = RD_SHIFT;
            end
            RD_SHIFT: begin
                if (cs_rise) state_nxt = IDLE;
            end
            WR_DATA: begin
                if (wr_last)      state_nxt = WR_COMMIT;
                else if (cs_rise) abort     = 1'b1;
            end
            WR_COMMIT: begin
                state_nxt = (cs_early || cs_rise) ? IDLE : WAIT_CS;
            end
            WAIT_CS: begin
                if (cs_rise) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg       <= '0;
            cnt         <= '0;
            reg_addr    <= '0;
            in_p2s      <= '0;
            head_flag   <= 1'b0;
            reg_rd_en   <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_wr_data <= '0;
            frame_err   <= 1'b0;
            cs_early    <= 1'b0;
        end else begin
            reg_rd_en <= (state == HDR) && (state_nxt == RD_FETCH);
            reg_wr_en <= (state_nxt == WR_COMMIT);
            head_flag <= (state_nxt == RD_SHIFT);
            frame_err <= abort || rsv_hit;
            cs_early  <= wr_last && cs_rise;
            if (state == IDLE) begin
                shreg <= '0;
                cnt   <= '0;
            end else if (sck_rise
                         && (state == HDR || state == WR_DATA)) begin
                shreg <= {shreg[DATA_W-3:0], mosi_s};
                cnt   <= (hdr_last || wr_last) ? '0 : cnt + 1'b1;
            end
            if (hdr_last && !cs_rise) reg_addr <= hdr_word[ADDR_W-1:0];
            if (wr_last) reg_wr_data <= wr_word;
            if (state == RD_FETCH && state_nxt == RD_ARM) begin
                in_p2s <= reg_rd_data;
            end
        end
    end

endmodule
